// File: rtl/plot_fb_writer_pkg.sv
// Shared types and constants for the pixel-plot framebuffer writer.
//   SCREEN_W / SCREEN_H : visible screen size; plots outside are clipped
//   FB_ADDR_W           : framebuffer word address width
//   FIFO_DEPTH          : plot buffer entries (power of two)
//   CLEAR_COLOUR        : colour written by a full-screen clear
//   plot_t              : one buffered plot {x, y, colour}
//   fb_state_t          : writer FSM states
package plot_fb_writer_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int FB_ADDR_W  = 15;
    localparam int FIFO_DEPTH = 8;

    typedef logic [2:0] colour_t;

    localparam colour_t CLEAR_COLOUR = 3'b000;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        colour_t    colour;
    } plot_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR,
        DONE
    } fb_state_t;

    // y*160 + x built from shifts: y*128 + y*32 + x.
    function automatic logic [FB_ADDR_W-1:0] fb_addr_f(input logic [7:0] x,
                                                       input logic [6:0] y);
        logic [FB_ADDR_W-1:0] yy;
        yy = FB_ADDR_W'(y);
        return (yy << 7) + (yy << 5) + FB_ADDR_W'(x);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot_t entries.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push_i     : enqueue wdata_i (ignored when full unless pop_i pops this cycle)
//   pop_i      : dequeue the head entry (ignored when empty)
//   head_o     : oldest entry
//   next_o     : entry behind the head (valid when count_o >= 2)
//   full_o, empty_o, count_o : occupancy
module plot_fifo
    import plot_fb_writer_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  plot_t                  wdata_i,
    output plot_t                  head_o,
    output plot_t                  next_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    plot_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        full_o   = (count_q == DEPTH_C);
        empty_o  = (count_q == '0);
        do_pop   = pop_i && !empty_o;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        head_o  = mem_q[rd_ptr_q];
        next_o  = mem_q[rd_ptr_q + AW'(1)];
        count_o = count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/plot_fb_writer.sv
// Receiving end of the pixel-plot interface. Clips off-screen plots, buffers
// accepted plots and drains them in order into a framebuffer write port; also
// performs a full-screen clear on request.
//   clk, rst_n                    : clock, synchronous active-low reset
//   vga_x/vga_y/vga_colour/vga_plot : incoming plot, one pixel per strobe
//   clear_start / clear_done      : level handshake for a full-screen clear
//   fb_addr/fb_wdata/fb_we/fb_ready : framebuffer write port (transfer on we&&ready)
//   busy                          : buffered plots pending or drain/clear active
//   overflow                      : sticky, an in-range plot was dropped
//   pixel_count / clip_count      : saturating plot-write / clipped-plot counters
module plot_fb_writer
    import plot_fb_writer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           vga_x,
    input  logic [6:0]           vga_y,
    input  logic [2:0]           vga_colour,
    input  logic                 vga_plot,
    input  logic                 clear_start,
    output logic                 clear_done,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [2:0]           fb_wdata,
    output logic                 fb_we,
    input  logic                 fb_ready,
    output logic                 busy,
    output logic                 overflow,
    output logic [15:0]          pixel_count,
    output logic [15:0]          clip_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FB_ADDR_W-1:0] CLR_TOTAL = FB_ADDR_W'(SCREEN_W * SCREEN_H);

    fb_state_t            state_q, state_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic [FB_ADDR_W-1:0] clr_q, clr_d;
    colour_t              wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic                 is_plot_q, is_plot_d;
    logic                 overflow_q, overflow_d;
    logic [15:0]          pix_q, pix_d;
    logic [15:0]          clip_q, clip_d;

    plot_t                in_plot, head, head_nxt;
    logic                 full, empty;
    logic [CNT_W-1:0]     count;
    logic                 in_range, push, pop, stall, drain_ok, clear_issue;

    plot_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_plot),
        .head_o  (head),
        .next_o  (head_nxt),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // A plot stays in the FIFO until its framebuffer write is accepted, so the
    // output register is only a registered copy of the head entry.
    always_comb begin
        in_plot     = '{x: vga_x, y: vga_y, colour: vga_colour};
        in_range    = (int'(vga_x) < SCREEN_W) && (int'(vga_y) < SCREEN_H);
        stall       = we_q && !fb_ready;
        pop         = we_q && fb_ready && is_plot_q;
        push        = vga_plot && in_range && (!full || pop);
        drain_ok    = (state_q == IDLE) || (state_q == DRAIN);
        clear_issue = (state_q == CLEAR) && !stall && (clr_q != CLR_TOTAL);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // Buffered plots take priority; a pending clear waits for them.
                if (count != '0) begin
                    state_d = DRAIN;
                end else if (clear_start) begin
                    state_d = CLEAR;
                end
            end
            DRAIN: begin
                if (pop && (count == CNT_W'(1)) && !push) begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if ((clr_q == CLR_TOTAL) && !stall) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!clear_start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write-port register, clear address counter and statistics.
    always_comb begin
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_plot_d = is_plot_q;
        clr_d     = '0;

        if (stall) begin
            we_d = 1'b1;
        end else if (drain_ok && !pop && (count != '0)) begin
            we_d      = 1'b1;
            addr_d    = fb_addr_f(head.x, head.y);
            wdata_d   = head.colour;
            is_plot_d = 1'b1;
        end else if (drain_ok && pop && (count > CNT_W'(1))) begin
            // Head completes this cycle: present the entry behind it back-to-back.
            we_d      = 1'b1;
            addr_d    = fb_addr_f(head_nxt.x, head_nxt.y);
            wdata_d   = head_nxt.colour;
            is_plot_d = 1'b1;
        end else if (clear_issue) begin
            we_d      = 1'b1;
            addr_d    = clr_q;
            wdata_d   = CLEAR_COLOUR;
            is_plot_d = 1'b0;
        end

        if (state_q == CLEAR) begin
            clr_d = clear_issue ? clr_q + FB_ADDR_W'(1) : clr_q;
        end

        pix_d      = pop ? sat_inc16(pix_q) : pix_q;
        clip_d     = (vga_plot && !in_range) ? sat_inc16(clip_q) : clip_q;
        overflow_d = overflow_q || (vga_plot && in_range && !push);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            is_plot_q  <= 1'b0;
            clr_q      <= '0;
            overflow_q <= 1'b0;
            pix_q      <= '0;
            clip_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            is_plot_q  <= is_plot_d;
            clr_q      <= clr_d;
            overflow_q <= overflow_d;
            pix_q      <= pix_d;
            clip_q     <= clip_d;
        end
    end

    assign fb_we       = we_q;
    assign fb_addr     = addr_q;
    assign fb_wdata    = wdata_q;
    assign clear_done  = (state_q == DONE);
    assign busy        = !empty || (state_q == DRAIN) || (state_q == CLEAR);
    assign overflow    = overflow_q;
    assign pixel_count = pix_q;
    assign clip_count  = clip_q;

endmodule

// File: tb/tb_plot_fb_writer.sv
module tb_plot_fb_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_start;
    logic        clear_done;
    logic [14:0] fb_addr;
    logic [2:0]  fb_wdata;
    logic        fb_we;
    logic        fb_ready;
    logic        busy;
    logic        overflow;
    logic [15:0] pixel_count;
    logic [15:0] clip_count;

    always #5 clk = ~clk;

    plot_fb_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .clear_start (clear_start),
        .clear_done  (clear_done),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .fb_we       (fb_we),
        .fb_ready    (fb_ready),
        .busy        (busy),
        .overflow    (overflow),
        .pixel_count (pixel_count),
        .clip_count  (clip_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model / write monitor ----------------
    // Pending plots are those accepted but whose write has not completed;
    // at most 8 may be pending. Writes must come out in acceptance order.
    typedef struct {
        logic [14:0] addr;
        logic [2:0]  col;
    } wr_t;

    wr_t         pend[$];
    int          m_clip = 0;
    int          m_pix  = 0;
    logic        m_ovf  = 1'b0;
    bit          clear_mode = 1'b0;
    int          clr_next = 0;
    int          clr_bad  = 0;
    int          hold_bad = 0;
    int          wr_count = 0;
    logic [14:0] last_addr = '0;
    logic [2:0]  last_col  = '0;
    logic        prev_stall = 1'b0;
    logic        prev_rst   = 1'b0;
    logic [14:0] prev_addr  = '0;
    logic [2:0]  prev_col   = '0;

    always @(negedge clk) begin
        wr_t w;
        int  a;
        if (!rst_n) begin
            pend.delete();
            m_clip = 0;
            m_pix  = 0;
            m_ovf  = 1'b0;
        end else begin
            if (prev_stall && prev_rst && (fb_addr !== prev_addr || fb_wdata !== prev_col))
                hold_bad++;
            if (fb_we && fb_ready) begin
                wr_count++;
                last_addr = fb_addr;
                last_col  = fb_wdata;
                if (clear_mode) begin
                    if (fb_addr !== 15'(clr_next) || fb_wdata !== 3'b000) clr_bad++;
                    clr_next++;
                end else if (pend.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_write: addr %0d colour %0d with nothing pending", fb_addr, fb_wdata);
                end else begin
                    w = pend.pop_front();
                    check("plot_wr_addr", 32'(fb_addr), 32'(w.addr));
                    check("plot_wr_col", 32'(fb_wdata), 32'(w.col));
                    m_pix++;
                end
            end
            if (vga_plot) begin
                if (vga_x >= 8'd160 || vga_y >= 7'd120) begin
                    m_clip++;
                end else if (pend.size() < 8) begin
                    a = int'(vga_y) * 160 + int'(vga_x);
                    w.addr = 15'(a);
                    w.col  = vga_colour;
                    pend.push_back(w);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (!clear_mode) clr_next = 0;
        prev_stall = fb_we && !fb_ready;
        prev_rst   = rst_n;
        prev_addr  = fb_addr;
        prev_col   = fb_wdata;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        vga_x      = x;
        vga_y      = y;
        vga_colour = c;
        vga_plot   = 1'b1;
        tick();
        vga_plot   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy === 1'b1 || fb_we === 1'b1) && k < 300) begin
            tick();
            k++;
        end
        check(name, 32'(busy), 0);
    endtask

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        bit         in;
        int         addr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, e_clip, k, hi, hb0, cb0;

        tbl[0] = '{8'd160, 7'd10,  3'd1, 1'b0, 0};
        tbl[1] = '{8'd5,   7'd120, 3'd2, 1'b0, 0};
        tbl[2] = '{8'd0,   7'd0,   3'd1, 1'b1, 0};
        tbl[3] = '{8'd159, 7'd119, 3'd7, 1'b1, 19199};
        tbl[4] = '{8'd159, 7'd0,   3'd2, 1'b1, 159};
        tbl[5] = '{8'd0,   7'd119, 3'd3, 1'b1, 19040};
        tbl[6] = '{8'd1,   7'd1,   3'd4, 1'b1, 161};
        tbl[7] = '{8'd255, 7'd127, 3'd6, 1'b0, 0};
        tbl[8] = '{8'd100, 7'd50,  3'd5, 1'b1, 8100};

        rst_n       = 1'b0;
        vga_x       = '0;
        vga_y       = '0;
        vga_colour  = '0;
        vga_plot    = 1'b0;
        clear_start = 1'b0;
        fb_ready    = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;

        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_wdata", 32'(fb_wdata), 0);
        check("rst_clear_done", 32'(clear_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_pixel_count", 32'(pixel_count), 0);
        check("rst_clip_count", 32'(clip_count), 0);

        // Single plot: accepted at edge N, write presented after edge N+1.
        send_plot(8'd80, 7'd60, 3'b101);
        check("first_we_not_early", 32'(fb_we), 0);
        tick();
        check("first_we", 32'(fb_we), 1);
        check("first_addr", 32'(fb_addr), 9680);
        check("first_wdata", 32'(fb_wdata), 5);
        tick();
        check("first_pixel_count", 32'(pixel_count), 1);

        // Table of plots: in-range ones write the given address, others clip.
        e_clip = 0;
        for (int i = 0; i < 9; i++) begin
            c0 = wr_count;
            send_plot(tbl[i].x, tbl[i].y, tbl[i].c);
            repeat (4) tick();
            check($sformatf("tbl%0d_writes", i), 32'(wr_count - c0), 32'(tbl[i].in));
            if (tbl[i].in) begin
                check($sformatf("tbl%0d_addr", i), 32'(last_addr), 32'(tbl[i].addr));
                check($sformatf("tbl%0d_col", i), 32'(last_col), 32'(tbl[i].c));
            end else begin
                e_clip++;
            end
            check($sformatf("tbl%0d_clip_count", i), 32'(clip_count), 32'(e_clip));
            if (i == 1) check("clip_no_overflow", 32'(overflow), 0);
        end
        check("tbl_pixel_count", 32'(pixel_count), 7);

        // Overflow: 9 plots with the framebuffer stalled, only 8 fit.
        fb_ready = 1'b0;
        c0 = wr_count;
        for (int i = 1; i <= 9; i++) send_plot(8'(10 * i), 7'(i), 3'(i));
        check("ovf_set", 32'(overflow), 1);
        repeat (3) tick();
        check("ovf_stall_we", 32'(fb_we), 1);
        check("ovf_stall_addr", 32'(fb_addr), 170);
        check("ovf_stall_wdata", 32'(fb_wdata), 1);
        check("ovf_no_writes_yet", 32'(wr_count - c0), 0);
        fb_ready = 1'b1;
        wait_idle("ovf_drain_idle");
        check("ovf_write_count", 32'(wr_count - c0), 8);
        check("ovf_last_addr", 32'(last_addr), 1360);
        check("ovf_pixel_count", 32'(pixel_count), 15);

        // Mid-drain stall for 3 cycles: outputs held, nothing skipped or duplicated.
        hb0 = hold_bad;
        c0 = wr_count;
        for (int i = 0; i < 4; i++) send_plot(8'(20 + i), 7'd30, 3'(i + 1));
        tick();
        fb_ready = 1'b0;
        repeat (3) tick();
        check("stall_addr", 32'(fb_addr), 4823);
        check("stall_wdata", 32'(fb_wdata), 4);
        fb_ready = 1'b1;
        wait_idle("stall_idle");
        check("stall_write_count", 32'(wr_count - c0), 4);
        check("stall_hold_violations", 32'(hold_bad - hb0), 0);
        check("stall_pixel_count", 32'(pixel_count), 19);

        // Randomized plots and backpressure against the model.
        for (int i = 0; i < 400; i++) begin
            vga_plot   = ($urandom_range(0, 9) < 6);
            vga_x      = 8'($urandom_range(0, 175));
            vga_y      = 7'($urandom_range(0, 127));
            vga_colour = 3'($urandom);
            fb_ready   = ($urandom_range(0, 1) == 1);
            tick();
        end
        vga_plot = 1'b0;
        fb_ready = 1'b1;
        wait_idle("rand_idle");
        check("rand_pending_left", 32'(pend.size()), 0);
        check("rand_pixel_count", 32'(pixel_count), 32'(m_pix));
        check("rand_clip_count", 32'(clip_count), 32'(m_clip));
        check("rand_overflow", 32'(overflow), 32'(m_ovf));
        check("rand_hold_violations", 32'(hold_bad - hb0), 0);

        // Full-screen clear, with two plots arriving mid-clear.
        cb0 = clr_bad;
        clear_mode  = 1'b1;
        c0 = wr_count;
        clear_start = 1'b1;
        repeat (5) tick();
        send_plot(8'd3, 7'd2, 3'd6);
        send_plot(8'd4, 7'd2, 3'd7);
        k = 0;
        while (clear_done !== 1'b1 && k < 25000) begin
            tick();
            k++;
        end
        check("clear_done_rise", 32'(clear_done), 1);
        check("clear_write_count", 32'(wr_count - c0), 19200);
        check("clear_bad_writes", 32'(clr_bad - cb0), 0);
        repeat (3) tick();
        check("clear_done_held", 32'(clear_done), 1);
        check("clear_no_plot_in_done", 32'(wr_count - c0), 19200);
        clear_mode  = 1'b0;
        clear_start = 1'b0;
        tick();
        check("clear_done_fall", 32'(clear_done), 0);
        wait_idle("clear_post_idle");
        check("clear_post_plots", 32'(wr_count - c0), 19202);
        check("clear_post_pending", 32'(pend.size()), 0);
        check("clear_pixel_count", 32'(pixel_count), 32'(m_pix));

        // Clear aborted by reset around write 500.
        clear_mode  = 1'b1;
        c0 = wr_count;
        clear_start = 1'b1;
        k = 0;
        while ((wr_count - c0) < 500 && k < 2000) begin
            tick();
            k++;
        end
        check("abort_reached_500", 32'((wr_count - c0) >= 500), 1);
        rst_n       = 1'b0;
        clear_start = 1'b0;
        tick();
        check("abort_we_low", 32'(fb_we), 0);
        check("abort_done_low", 32'(clear_done), 0);
        tick();
        rst_n      = 1'b1;
        clear_mode = 1'b0;
        hi = 0;
        repeat (50) begin
            tick();
            if (clear_done !== 1'b0 || fb_we !== 1'b0) hi++;
        end
        check("abort_done_never", 32'(hi), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_pixel_count", 32'(pixel_count), 0);
        check("abort_overflow", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
